// File: rtl/spi_cs_sequencer_pkg.sv
// Shared types and helpers for the SPI chip-select sequencer.
package spi_cs_pkg;

    // FSM states; encodings double as the state_num debug output.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SELECT = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } cs_state_t;

    // Bits needed to index n items, never less than one.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/spi_cs_sequencer_next_pick.sv
// Combinational picker: lowest set mask bit (first) or lowest set bit above i_cur.
module cs_next_pick
    import spi_cs_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned IW     = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [IW-1:0]     i_cur,
    input  logic              i_first,
    output logic [IW-1:0]     o_idx,
    output logic              o_vld
);

    logic          w_found;
    logic [IW-1:0] w_idx;

    // Scan upward, keeping the first qualifying index.
    always_comb begin
        w_found = 1'b0;
        w_idx   = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (!w_found && i_mask[i] && (i_first || (i > 32'(i_cur)))) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
            end
        end
    end

    assign o_idx = w_idx;
    assign o_vld = w_found;

endmodule

// File: rtl/spi_cs_sequencer.sv
// Per-window chip-select sequencer: walks every enabled slave in ascending
// order, holding CS low until the SPI master's sent pulse, then a CS-high gap.
// Optional macro SPI_CS_TIMEOUT_EN adds a per-slave timeout with timeout_err.
module spi_cs_sequencer
    import spi_cs_pkg::*;
#(
    parameter int unsigned NUM_CH      = 4,
    parameter int unsigned CS_GAP      = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en_10,
    input  logic [NUM_CH-1:0]              ch_mask,
    input  logic                           sent,
    output logic [NUM_CH-1:0]              cs_n,
    output logic [idx_width(NUM_CH)-1:0]   active_ch,
    output logic [1:0]                     state_num,
    output logic                           frame_done,
    output logic                           timeout_err
);

    localparam int unsigned IW = idx_width(NUM_CH);
    localparam int unsigned GW = idx_width(CS_GAP);

    if (NUM_CH == 0 || NUM_CH > 16 || CS_GAP == 0 || TIMEOUT_CYC == 0) begin : g_param_err
        $error("spi_cs_sequencer: parameter out of range");
    end

    cs_state_t           r_state;
    logic [IW-1:0]       r_act;
    logic [IW-1:0]       r_next_idx;
    logic [NUM_CH-1:0]   r_mask;
    logic [GW-1:0]       r_gap_cnt;
    logic [NUM_CH-1:0]   r_cs_n;
    logic                r_frame_done;

    cs_state_t           w_state_nxt;
    logic [IW-1:0]       w_act_nxt;
    logic [IW-1:0]       w_next_idx_nxt;
    logic [NUM_CH-1:0]   w_mask_nxt;
    logic [GW-1:0]       w_gap_nxt;
    logic [NUM_CH-1:0]   w_cs_n_nxt;
    logic                w_to_hit;

    logic [NUM_CH-1:0]   w_pick_mask;
    logic                w_pick_first;
    logic [IW-1:0]       w_pick_idx;
    logic                w_pick_vld;

    // In IDLE the picker looks at the live mask for the first slave; afterwards
    // it walks the latched mask above the current index.
    assign w_pick_first = (r_state == IDLE);
    assign w_pick_mask  = w_pick_first ? ch_mask : r_mask;

    cs_next_pick #(
        .NUM_CH (NUM_CH),
        .IW     (IW)
    ) u_pick (
        .i_mask  (w_pick_mask),
        .i_cur   (r_act),
        .i_first (w_pick_first),
        .o_idx   (w_pick_idx),
        .o_vld   (w_pick_vld)
    );

    // Next-state, next-index and next chip-select decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_act_nxt      = r_act;
        w_next_idx_nxt = r_next_idx;
        w_mask_nxt     = r_mask;
        w_gap_nxt      = '0;
        w_cs_n_nxt     = '1;

        case (r_state)
            IDLE: begin
                if (en_10) begin
                    w_mask_nxt = ch_mask;
                    if (w_pick_vld) begin
                        w_act_nxt   = w_pick_idx;
                        w_state_nxt = SELECT;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            SELECT: begin
                if (!en_10) begin
                    w_state_nxt = IDLE;
                end else if (sent || w_to_hit) begin
                    if (w_pick_vld) begin
                        w_next_idx_nxt = w_pick_idx;
                        w_state_nxt    = GAP;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            GAP: begin
                if (!en_10) begin
                    w_state_nxt = IDLE;
                end else if (r_gap_cnt == GW'(CS_GAP - 1)) begin
                    w_act_nxt   = r_next_idx;
                    w_state_nxt = SELECT;
                end else begin
                    w_gap_nxt = r_gap_cnt + GW'(1);
                end
            end
            DONE: begin
                if (!en_10) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase

        // CS is decoded from the next state so it moves on the same edge as the FSM.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_cs_n_nxt[i] = !((w_state_nxt == SELECT) && (w_act_nxt == IW'(i)));
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_act        <= '0;
            r_next_idx   <= '0;
            r_mask       <= '0;
            r_gap_cnt    <= '0;
            r_cs_n       <= '1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_act        <= w_act_nxt;
            r_next_idx   <= w_next_idx_nxt;
            r_mask       <= w_mask_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_cs_n       <= w_cs_n_nxt;
            r_frame_done <= (w_state_nxt == DONE) && (r_state != DONE);
        end
    end

`ifdef SPI_CS_TIMEOUT_EN
    localparam int unsigned TW = idx_width(TIMEOUT_CYC);

    logic [TW-1:0] r_to_cnt;
    logic          r_to_err;

    assign w_to_hit = (r_state == SELECT) && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    // Timeout counter runs only while staying in SELECT; any entry restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_to_cnt <= ((r_state == SELECT) && (w_state_nxt == SELECT)) ? r_to_cnt + TW'(1) : '0;
            r_to_err <= w_to_hit && en_10 && !sent;
        end
    end

    assign timeout_err = r_to_err;
`else
    assign w_to_hit    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign cs_n       = r_cs_n;
    assign active_ch  = r_act;
    assign state_num  = r_state;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_spi_cs_sequencer.sv
// Self-checking bench for spi_cs_sequencer; frames are checked against a
// per-frame expected trace built from the channel list and sent timing.
module tb_spi_cs_sequencer;

    localparam int NCH = 4;
    localparam int GAP = 2;
    localparam int TO  = 8;
`ifdef SPI_CS_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic           en_10;
    logic [NCH-1:0] ch_mask;
    logic           sent;
    logic [NCH-1:0] cs_n;
    logic [1:0]     active_ch;
    logic [1:0]     state_num;
    logic           frame_done;
    logic           timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] model_act = 2'd0;

    spi_cs_sequencer #(
        .NUM_CH      (NCH),
        .CS_GAP      (GAP),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en_10       (en_10),
        .ch_mask     (ch_mask),
        .sent        (sent),
        .cs_n        (cs_n),
        .active_ch   (active_ch),
        .state_num   (state_num),
        .frame_done  (frame_done),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en_10 = 1'b0; sent = 1'b0; ch_mask = '0;
        step(); step();
        n_checks++;
        if (cs_n !== 4'b1111 || active_ch !== 2'd0 || state_num !== 2'd0 ||
            frame_done !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset outs got cs=%b act=%0d st=%0d fd=%b te=%b exp cs=1111 act=0 st=0 fd=0 te=0",
                     cs_n, active_ch, state_num, frame_done, timeout_err);
        end
        rst = 1'b0;
        step();
        model_act = 2'd0;
    endtask

    // Runs one full window. mid < 0 randomises ch_mask every cycle of the frame.
    task automatic run_frame(input logic [3:0] mask, input int fixed_dly, input int mid, input string name);
        logic [3:0] q_cs[$];
        logic [1:0] q_st[$];
        logic [1:0] q_act[$];
        logic       q_fd[$];
        logic       q_te[$];
        logic       q_sent[$];
        int         chans[$];
        bit         pend_te;
        int         dly;
        int         cyc;
        pend_te = 1'b0;
        for (int c = 0; c < NCH; c++) if (mask[c]) chans.push_back(c);
        for (int k = 0; k < chans.size(); k++) begin
            dly = (fixed_dly > 0) ? fixed_dly : int'($urandom_range(1, TO_ON ? 10 : 5));
            cyc = (TO_ON && dly > TO) ? TO : dly;
            for (int t = 0; t < cyc; t++) begin
                q_cs.push_back(~(4'b0001 << chans[k]));
                q_st.push_back(2'd1);
                q_act.push_back(2'(chans[k]));
                q_fd.push_back(1'b0);
                q_te.push_back(1'b0);
                q_sent.push_back(t == dly - 1);
            end
            pend_te = TO_ON && (dly > TO);
            model_act = 2'(chans[k]);
            if (k != chans.size() - 1) begin
                for (int g = 0; g < GAP; g++) begin
                    q_cs.push_back(4'b1111);
                    q_st.push_back(2'd2);
                    q_act.push_back(model_act);
                    q_fd.push_back(1'b0);
                    q_te.push_back((g == 0) ? pend_te : 1'b0);
                    q_sent.push_back(1'($urandom));
                end
                pend_te = 1'b0;
            end
        end
        for (int d = 0; d < 4; d++) begin
            q_cs.push_back(4'b1111);
            q_st.push_back(2'd3);
            q_act.push_back(model_act);
            q_fd.push_back(d == 0);
            q_te.push_back((d == 0) ? pend_te : 1'b0);
            q_sent.push_back(1'($urandom));
        end

        ch_mask = mask; en_10 = 1'b1; sent = 1'b0;
        step();
        for (int i = 0; i < q_cs.size(); i++) begin
            n_checks++;
            if (cs_n !== q_cs[i]) begin
                n_fail++;
                $display("FAIL %s cs_n cyc%0d got=%b exp=%b", name, i, cs_n, q_cs[i]);
            end
            n_checks++;
            if (state_num !== q_st[i]) begin
                n_fail++;
                $display("FAIL %s state_num cyc%0d got=%0d exp=%0d", name, i, state_num, q_st[i]);
            end
            n_checks++;
            if (active_ch !== q_act[i]) begin
                n_fail++;
                $display("FAIL %s active_ch cyc%0d got=%0d exp=%0d", name, i, active_ch, q_act[i]);
            end
            n_checks++;
            if (frame_done !== q_fd[i]) begin
                n_fail++;
                $display("FAIL %s frame_done cyc%0d got=%b exp=%b", name, i, frame_done, q_fd[i]);
            end
            n_checks++;
            if (timeout_err !== q_te[i]) begin
                n_fail++;
                $display("FAIL %s timeout_err cyc%0d got=%b exp=%b", name, i, timeout_err, q_te[i]);
            end
            sent = q_sent[i];
            ch_mask = (mid < 0) ? 4'($urandom) : 4'(mid);
            step();
        end
        en_10 = 1'b0; sent = 1'b0;
        step();
        n_checks++;
        if (state_num !== 2'd0 || cs_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL %s end idle got st=%0d cs=%b exp st=0 cs=1111", name, state_num, cs_n);
        end
    endtask

    task automatic test_fixed_frame();
        run_frame(4'b1011, 3, 4'b1011, "fixed_1011");
    endtask

    task automatic test_empty_mask();
        run_frame(4'b0000, 0, 0, "empty_mask");
    endtask

    task automatic test_mask_change();
        run_frame(4'b0011, 0, 4'b1100, "mask_change");
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 25; n++) run_frame(4'($urandom), 0, -1, "rand_frame");
    endtask

    task automatic test_abort();
        ch_mask = 4'b0011; en_10 = 1'b1; sent = 1'b0;
        step();
        n_checks++;
        if (cs_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL abort_sel cs_n got=%b exp=1110", cs_n);
        end
        en_10 = 1'b0; sent = 1'b1;
        step();
        n_checks++;
        if (cs_n !== 4'b1111 || state_num !== 2'd0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_select got cs=%b st=%0d fd=%b exp cs=1111 st=0 fd=0", cs_n, state_num, frame_done);
        end
        sent = 1'b0; en_10 = 1'b1;
        step();
        sent = 1'b1;
        step();
        n_checks++;
        if (state_num !== 2'd2 || cs_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL abort_gap_entry got st=%0d cs=%b exp st=2 cs=1111", state_num, cs_n);
        end
        sent = 1'b0; en_10 = 1'b0;
        step();
        n_checks++;
        if (state_num !== 2'd0 || cs_n !== 4'b1111 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_gap got st=%0d cs=%b fd=%b exp st=0 cs=1111 fd=0", state_num, cs_n, frame_done);
        end
        model_act = 2'd0;
    endtask

    task automatic test_reset_midframe();
        ch_mask = 4'b0100; en_10 = 1'b1; sent = 1'b0;
        step();
        n_checks++;
        if (cs_n !== 4'b1011 || active_ch !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_mid_sel got cs=%b act=%0d exp cs=1011 act=2", cs_n, active_ch);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if (cs_n !== 4'b1111 || active_ch !== 2'd0 || state_num !== 2'd0 ||
            frame_done !== 1'b0 || timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid got cs=%b act=%0d st=%0d fd=%b te=%b exp 1111/0/0/0/0",
                     cs_n, active_ch, state_num, frame_done, timeout_err);
        end
        rst = 1'b0; en_10 = 1'b0;
        step();
        model_act = 2'd0;
        run_frame(4'b1101, 0, -1, "after_rst");
    endtask

`ifdef SPI_CS_TIMEOUT_EN
    task automatic test_timeout();
        run_frame(4'b0011, 100, -1, "timeout");
        run_frame(4'b0110, TO, -1, "sent_at_timeout");
    endtask
`else
    task automatic test_no_timeout();
        ch_mask = 4'b0011; en_10 = 1'b1; sent = 1'b0;
        step();
        for (int i = 0; i < 5 * TO; i++) begin
            n_checks++;
            if (cs_n !== 4'b1110 || timeout_err !== 1'b0) begin
                n_fail++;
                $display("FAIL no_timeout cyc%0d got cs=%b te=%b exp cs=1110 te=0", i, cs_n, timeout_err);
            end
            step();
        end
        en_10 = 1'b0;
        step();
        n_checks++;
        if (state_num !== 2'd0 || cs_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL no_timeout_abort got st=%0d cs=%b exp st=0 cs=1111", state_num, cs_n);
        end
        model_act = 2'd0;
    endtask
`endif

    initial begin
        test_reset();
        test_fixed_frame();
        test_empty_mask();
        test_abort();
        test_reset_midframe();
        test_mask_change();
`ifdef SPI_CS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
